// File: rtl/div_seq.sv
// Restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock; N cycles accept->done, 1 cycle for errors.
// No backpressure: start is accepted only while idle and ignored while busy; results hold until the next accept.
module div_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] P,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           ovf,
  output logic           dbz
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ERR} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Partial remainder always stays below the divisor, so its top bit is implicit zero.
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    work_q, work_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    r_q, r_d;
  logic            ovf_q, ovf_d;
  logic            dbz_q, dbz_d;
  logic            done_q, done_d;

  logic [N:0]      t;
  logic            ge;
  logic [N-1:0]    diff;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (B == '0 || P[2*N-1:N] >= B) state_d = S_ERR;
          else                            state_d = S_CALC;
        end
      end
      S_CALC:  if (cnt_q == CW'(1)) state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Shift the next dividend bit in; a modular N-bit subtract is exact whenever t >= B.
  always_comb begin
    t    = {rem_q, work_q[N-1]};
    ge   = (t >= {1'b0, b_q});
    diff = t[N-1:0] - b_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    work_d = work_q;
    b_d    = b_q;
    q_d    = q_q;
    r_d    = r_q;
    ovf_d  = ovf_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d    = B;
          work_d = P[N-1:0];
          rem_d  = P[2*N-1:N];
          cnt_d  = CW'(N);
          ovf_d  = 1'b0;
          dbz_d  = 1'b0;
        end
      end
      S_CALC: begin
        rem_d  = ge ? diff : t[N-1:0];
        work_d = {work_q[N-2:0], ge};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d    = {work_q[N-2:0], ge};
          r_d    = ge ? diff : t[N-1:0];
          done_d = 1'b1;
        end
      end
      S_ERR: begin
        done_d = 1'b1;
        q_d    = '1;
        if (b_q == '0) begin
          dbz_d = 1'b1;
          ovf_d = 1'b0;
          r_d   = work_q;
        end else begin
          dbz_d = 1'b0;
          ovf_d = 1'b1;
          r_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      work_q <= '0;
      b_q    <= '0;
      q_q    <= '0;
      r_q    <= '0;
      ovf_q  <= 1'b0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      work_q <= work_d;
      b_q    <= b_d;
      q_q    <= q_d;
      r_q    <= r_d;
      ovf_q  <= ovf_d;
      dbz_q  <= dbz_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential restoring divider: the inverse of the pipelined multiplier `mul`.
- Takes a 2N-bit product-width dividend and an N-bit divisor. Returns an N-bit quotient and an N-bit remainder, so it can undo `mul` output (P / B -> A).
- Iterative, one quotient bit per clock, start/busy/done handshake.
- Sits beside `mul` in the arithmetic datapath.

Parameters:
- N, 4, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset; sampled on rising edge of clk, low = reset.
- start  input  1  request pulse/level; accepted only in IDLE.
- P  input  2N  dividend; sampled on the accepting edge.
- B  input  N  divisor; sampled on the accepting edge.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; Q/R/ovf/dbz valid from this cycle.
- Q  output  N  quotient, held until next accept.
- R  output  N  remainder, held until next accept.
- ovf  output  1  quotient overflow (true quotient >= 2^N).
- dbz  output  1  divide by zero.

Behaviour:
- Reset (rst low at an edge): state=IDLE; busy=0, done=0, Q=0, R=0, ovf=0, dbz=0; internal counter/remainder cleared.
- Reset mid-operation aborts immediately, with no done pulse.
- States:
  - IDLE: wait for start.
  - CALC: N iterations.
  - ERR: one-cycle error completion.
- IDLE + start at edge k:
  - Register P and B; clear ovf, dbz, done.
  - Set busy=1.
  - If B==0 -> ERR. Else if P[2N-1:N] >= B -> ERR. Else -> CALC, counter=N.
- ERR (one cycle), at edge k+1:
  - done=1, busy=0, Q=all ones, state->IDLE.
  - B==0: dbz=1, ovf=0, R=P[N-1:0].
  - Overflow: ovf=1, dbz=0, R=0.
  - dbz has priority when both conditions hold.
- CALC, one iteration per edge:
  - Partial remainder rem is N+1 bits, initialised to {0,P[2N-1:N]}.
  - Low dividend bits are shifted in MSB first.
  - Each step: t={rem[N-1:0], next bit}. If t>=B: rem=t-B, qbit=1; else rem=t, qbit=0.
  - qbit is shifted into the quotient LSB.
- Completion: on edge k+N the final iteration writes Q and R=rem[N-1:0], sets done=1, busy=0, state->IDLE.
- Latency: N cycles from accept to done for valid ops; 1 cycle for error ops.
- done is high for exactly one cycle, then returns to 0.
- Q, R, ovf and dbz hold their values until the next accept.
- start while busy=1 is ignored; inputs are not re-sampled.
- start in the done cycle is accepted, because state is IDLE. done falls and busy rises on that edge, so back-to-back throughput is one op per N cycles.
- P and B may change freely after the accepting edge; the result depends only on sampled values.
- Invariant for every non-error op: Q*B+R == P, and R < B.
- No combinational path from inputs to outputs.

Test Plan (N=4, 10-unit clock):
1. Reset hold, then release, then start with P=8'h48 (72), B=9 -> busy=1 for 4 cycles. done pulses 4 cycles after accept with Q=8, R=0, ovf=0, dbz=0.
2. P=20, B=3 -> Q=6, R=2. Then P=225, B=15 -> Q=15, R=0. Check Q*B+R==P for each.
3. Errors:
   - P=8'hF0, B=15 -> done 1 cycle after accept; ovf=1, Q=4'hF, R=0.
   - P=8'h2A, B=0 -> dbz=1, ovf=0, Q=4'hF, R=4'hA.
4. Handshake: while busy, pulse start with P=50, B=5 -> ignored; first result is unchanged. Then hold start high through the done cycle with P=50, B=5 -> second op accepted at the done edge; Q=10, R=0 four cycles later.
5. Reset mid-op: drive rst low 2 cycles into a P=72/B=9 op -> next edge all outputs 0, busy=0, no done pulse. Release, then a fresh op P=63/B=7 -> Q=9, R=0.
6. Exhaustive sweep: all P < B*16, B in 1..15 -> every result satisfies Q*B+R==P and R<B; no ovf/dbz.
